// File: rtl/code_sender.sv
// Colour-code lock transmitter: sends Start plus GROUPS colour groups, samples U, reports via Go/Busy/Done.
// Optional brute-force sweep of the code space is enabled with `define CODE_SWEEP_EN.
module code_sender #(
    parameter int GROUPS = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Go,
    input  logic [3*GROUPS-1:0]   Code,
`ifdef CODE_SWEEP_EN
    input  logic                  Sweep,
    output logic [3*GROUPS-1:0]   Found_Code,
`endif
    output logic                  Busy,
    output logic                  Done,
    output logic                  Match,
    output logic                  Start,
    output logic                  Red,
    output logic                  Green,
    output logic                  Blue,
    output logic                  DetRst,
    input  logic                  U
);

    localparam int CW = 3 * GROUPS;
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {IDLE, START, GRP, CHECK} state_t;

    state_t        state;
    logic [GW-1:0] grp;
    logic [CW-1:0] shreg;
`ifdef CODE_SWEEP_EN
    logic          sweep_q;
    logic [CW-1:0] cnt;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            grp    <= '0;
            shreg  <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Match  <= 1'b0;
            Start  <= 1'b0;
            Red    <= 1'b0;
            Green  <= 1'b0;
            Blue   <= 1'b0;
            DetRst <= 1'b1;
`ifdef CODE_SWEEP_EN
            sweep_q    <= 1'b0;
            cnt        <= '0;
            Found_Code <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Go) begin
`ifdef CODE_SWEEP_EN
                        sweep_q <= Sweep;
                        cnt     <= '0;
                        shreg   <= Sweep ? '0 : Code;
`else
                        shreg   <= Code;
`endif
                        Match  <= 1'b0;
                        Busy   <= 1'b1;
                        Start  <= 1'b1;
                        DetRst <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    // shreg holds the remaining groups, lowest group in bits [2:0]
                    Start               <= 1'b0;
                    {Red, Green, Blue}  <= shreg[2:0];
                    shreg               <= shreg >> 3;
                    grp                 <= '0;
                    state               <= GRP;
                end
                GRP: begin
                    if (grp == GW'(GROUPS - 1)) begin
                        {Red, Green, Blue} <= 3'b000;
                        DetRst             <= 1'b1;
                        state              <= CHECK;
                    end else begin
                        {Red, Green, Blue} <= shreg[2:0];
                        shreg              <= shreg >> 3;
                        grp                <= grp + 1'b1;
                    end
                end
                CHECK: begin
`ifdef CODE_SWEEP_EN
                    if (sweep_q && !U && cnt != '1) begin
                        cnt    <= cnt + 1'b1;
                        shreg  <= cnt + 1'b1;
                        Start  <= 1'b1;
                        DetRst <= 1'b0;
                        state  <= START;
                    end else begin
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        Match <= U;
                        state <= IDLE;
                        if (sweep_q) Found_Code <= U ? cnt : '0;
                    end
`else
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    Match <= U;
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_code_sender.sv
// Self-checking bench for code_sender with a behavioural Code_Detector; sweep tests under CODE_SWEEP_EN.
module tb_code_sender;

    localparam int GROUPS = 4;
    localparam int CW     = 3 * GROUPS;
    localparam int LAT    = GROUPS + 3;

    logic          Clk = 1'b0;
    logic          Rst, Go, U;
    logic [CW-1:0] Code;
    logic          Busy, Done, Match, Start, Red, Green, Blue, DetRst;
`ifdef CODE_SWEEP_EN
    logic          Sweep;
    logic [CW-1:0] Found_Code;
`endif

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    code_sender #(.GROUPS(GROUPS)) dut (
        .Clk(Clk), .Rst(Rst), .Go(Go), .Code(Code),
`ifdef CODE_SWEEP_EN
        .Sweep(Sweep), .Found_Code(Found_Code),
`endif
        .Busy(Busy), .Done(Done), .Match(Match), .Start(Start),
        .Red(Red), .Green(Green), .Blue(Blue), .DetRst(DetRst), .U(U)
    );

    // Detector: collects the groups following Start while out of reset, unlocks on a full match.
    logic [CW-1:0] det_code = '0;
    logic          det_en   = 1'b0;
    logic [CW-1:0] got      = '0;
    int            got_n    = 0;

    always @(posedge Clk) begin
        if (DetRst || Start) begin
            got_n <= 0;
            got   <= '0;
        end else if (got_n < GROUPS) begin
            got[3*got_n +: 3] <= {Red, Green, Blue};
            got_n             <= got_n + 1;
        end
    end
    assign U = det_en && (got_n == GROUPS) && (got == det_code);

    logic [6:0] obs;
    assign obs = {Busy, Done, Start, Red, Green, Blue, DetRst};
    localparam logic [6:0] IDLE_VEC = 7'b0000001;

    typedef struct {
        logic [CW-1:0] code;
        logic [CW-1:0] target;
        logic          match;
    } vec_t;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {Busy,Done,Start,R,G,B,DetRst} in cycle c of an attempt (Go sampled at edge 0).
    function automatic logic [6:0] exp_vec(input int c, input logic [CW-1:0] code);
        logic [2:0]    rgb;
        logic [CW-1:0] sh;
        rgb = 3'b000;
        if (c >= 2 && c <= GROUPS + 1) begin
            sh  = code >> (3 * (c - 2));
            rgb = sh[2:0];
        end
        return {(c >= 1 && c <= GROUPS + 2), (c == GROUPS + 3), (c == 1), rgb,
                !(c >= 1 && c <= GROUPS + 1)};
    endfunction

    // Starts from IDLE; returns positioned in the Done cycle.
    task automatic run_attempt(input logic [CW-1:0] code, input logic [CW-1:0] target,
                               input logic exp_match, input bit go_in_c3);
        det_code = target;
        det_en   = 1'b1;
        Code     = code;
        Go       = 1'b1;
        tick();
        Go   = 1'b0;
        Code = CW'($urandom);
        for (int c = 1; c <= LAT; c++) begin
            check($sformatf("trace code=%o c%0d", code, c), obs, exp_vec(c, code));
            if (c == LAT) check($sformatf("match code=%o", code), Match, exp_match);
            if (go_in_c3 && c == 3) begin
                Go   = 1'b1;
                Code = ~code;
            end else begin
                Go = 1'b0;
            end
            if (c < LAT) tick();
        end
    endtask

`ifdef CODE_SWEEP_EN
    task automatic run_sweep(input logic [CW-1:0] target, input logic en, input int exp_cycles,
                             input logic exp_match, input logic [CW-1:0] exp_found);
        int n;
        det_code = target;
        det_en   = en;
        Sweep    = 1'b1;
        Go       = 1'b1;
        Code     = CW'($urandom);
        tick();
        Go    = 1'b0;
        Sweep = 1'b0;
        n     = 1;
        while (!Done && n < 30000) begin
            tick();
            n++;
        end
        check("sweep latency", n, exp_cycles);
        check("sweep match", Match, exp_match);
        check("sweep found", Found_Code, exp_found);
        check("sweep busy low", Busy, 1'b0);
        tick();
        check("sweep done pulse", Done, 1'b0);
    endtask
`endif

    vec_t vecs[6];

    initial begin
        vecs[0] = '{12'o5213, 12'o5213, 1'b1};
        vecs[1] = '{12'o5212, 12'o5213, 1'b0};
        vecs[2] = '{12'o0000, 12'o0000, 1'b1};
        vecs[3] = '{12'o7777, 12'o7777, 1'b1};
        vecs[4] = '{12'o7777, 12'o3777, 1'b0};
        vecs[5] = '{12'o1234, 12'o4321, 1'b0};

        Rst  = 1'b1;
        Go   = 1'b0;
        Code = '0;
`ifdef CODE_SWEEP_EN
        Sweep = 1'b0;
`endif
        tick();
        tick();
        check("reset outputs", obs, IDLE_VEC);
        check("reset match", Match, 1'b0);
`ifdef CODE_SWEEP_EN
        check("reset found", Found_Code, '0);
`endif
        Rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_attempt(vecs[i].code, vecs[i].target, vecs[i].match, 1'b0);
            tick();
            check("idle after done", obs, IDLE_VEC);
            check("match held", Match, vecs[i].match);
        end

        // Go pulsed mid-attempt with another code is ignored: one Done, original code sent
        run_attempt(12'o5213, 12'o5213, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("no second done k%0d", k), obs, IDLE_VEC);
        end

        // Reset in cycle 4 aborts the attempt without a Done
        det_code = 12'o5213;
        Code     = 12'o5213;
        Go       = 1'b1;
        tick();
        Go = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        Rst = 1'b1;
        tick();
        check("abort outputs", obs, IDLE_VEC);
        check("abort match", Match, 1'b0);
        Rst = 1'b0;
        for (int k = 0; k < GROUPS + 3; k++) begin
            tick();
            check($sformatf("abort idle k%0d", k), obs, IDLE_VEC);
        end
        run_attempt(12'o5213, 12'o5213, 1'b1, 1'b0);
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("reset clears match", Match, 1'b0);
        tick();

        // Go held high: back-to-back attempts with period GROUPS+3
        det_code = 12'o6145;
        det_en   = 1'b1;
        Code     = 12'o6145;
        Go       = 1'b1;
        tick();
        for (int c = 1; c <= 2 * LAT; c++) begin
            int cc;
            cc = (c <= LAT) ? c : c - LAT;
            check($sformatf("held go c%0d", c), obs, exp_vec(cc, 12'o6145));
            if (c == 2 * LAT) check("held go match", Match, 1'b1);
            if (c == 2 * LAT) Go = 1'b0;
            if (c < 2 * LAT) tick();
        end
        tick();
        check("held go idle", obs, IDLE_VEC);

        // Randomized attempts against the detector model
        for (int r = 0; r < 40; r++) begin
            logic [CW-1:0] t, c;
            t = CW'($urandom);
            c = ($urandom_range(0, 1) == 0) ? t : CW'($urandom);
            run_attempt(c, t, (c == t), 1'b0);
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();

`ifdef CODE_SWEEP_EN
        run_sweep(12'd7, 1'b1, 8 * (GROUPS + 2) + 1, 1'b1, 12'd7);
        run_sweep(12'd0, 1'b0, 4096 * (GROUPS + 2) + 1, 1'b0, 12'd0);
        run_attempt(12'o5213, 12'o5213, 1'b1, 1'b0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
